ccip_c0_line_credit: RTL and testbench

CCIP_C0_LINE_CREDIT -- requirements
Module: ccip_c0_line_credit

---
 rtl/ccip_c0_line_credit.sv | 101 ++++++++++
 tb/tb_ccip_c0_line_credit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_line_credit.sv
// ccip_c0_line_credit
// Line-granular credit tracker for the CCI-P c0 (read) channel. Counts the
// response lines still owed to the AFU, gates new read requests so the
// in-flight total never exceeds MAX_ACTIVE_LINES, records the peak occupancy,
// and latches sticky error flags for illegal lengths and stray responses.

module ccip_c0_line_credit #(
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [1:0]       req_cl_len,
    output logic             req_ready,
    input  logic             rsp_valid,
    input  logic             clr_peak,
    output logic [CNT_W-1:0] active_lines,
    output logic [CNT_W-1:0] peak_lines,
    output logic             err_len,
    output logic             err_underflow
);

    // One spare bit so active_lines + n can be compared without wrapping.
    localparam logic [CNT_W:0] MAX_LINES = (CNT_W+1)'(MAX_ACTIVE_LINES);

    // t_ccip_clLen encodings.
    localparam logic [1:0] CL_LEN_1 = 2'd0;
    localparam logic [1:0] CL_LEN_2 = 2'd1;
    localparam logic [1:0] CL_LEN_4 = 2'd3;

    logic [2:0]       req_lines;
    logic             len_legal;
    logic [CNT_W:0]   req_sum;
    logic             accept;
    logic [CNT_W-1:0] active_inc;
    logic [CNT_W-1:0] active_next;
    logic [CNT_W-1:0] peak_next;
    logic             underflow;

    // Decode the request length into a line count and legality flag.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can infer a latch.
        req_lines = 3'd0;
        len_legal = 1'b0;
        case (req_cl_len)
            CL_LEN_1: begin req_lines = 3'd1; len_legal = 1'b1; end
            CL_LEN_2: begin req_lines = 3'd2; len_legal = 1'b1; end
            CL_LEN_4: begin req_lines = 3'd4; len_legal = 1'b1; end
            default:  begin req_lines = 3'd0; len_legal = 1'b0; end
        endcase
    end

    // Credit check: uses only the registered count, so a response returning
    // in this same cycle is deliberately not credited.
    always_comb begin
        req_sum   = {1'b0, active_lines} + (CNT_W+1)'(req_lines);
        req_ready = len_legal && (req_sum <= MAX_LINES);
        accept    = req_valid && req_ready;
    end

    // Next count: add the accepted lines first, then retire one line if a
    // response arrived. Retiring from zero is an underflow and the count holds;
    // an accept in the same cycle supplies the line being retired.
    always_comb begin
        active_inc  = accept ? req_sum[CNT_W-1:0] : active_lines;
        underflow   = rsp_valid && (active_inc == '0);
        active_next = active_inc;
        if (rsp_valid && !underflow) begin
            active_next = active_inc - 1'b1;
        end
        if (clr_peak) begin
            peak_next = active_next;
        end else begin
            peak_next = (active_next > peak_lines) ? active_next : peak_lines;
        end
    end

    // Register the occupancy, its peak and the sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_lines  <= '0;
            peak_lines    <= '0;
            err_len       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            active_lines <= active_next;
            peak_lines   <= peak_next;
            if (req_valid && (req_cl_len == 2'd2)) begin
                err_len <= 1'b1;
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_c0_line_credit.sv
// Self-checking bench for ccip_c0_line_credit with MAX_ACTIVE_LINES = 8.
// A table of directed single-cycle vectors with hand-computed expectations,
// followed by hand-written sequences for underflow and asynchronous reset.

module tb_ccip_c0_line_credit;

    localparam int MAX   = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             req_valid;
    logic [1:0]       req_cl_len;
    logic             req_ready;
    logic             rsp_valid;
    logic             clr_peak;
    logic [CNT_W-1:0] active_lines;
    logic [CNT_W-1:0] peak_lines;
    logic             err_len;
    logic             err_underflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       valid;
        logic [1:0] cl_len;
        logic       rsp;
        logic       clr;
        logic       exp_ready;
        int         exp_active;
        int         exp_peak;
        logic       exp_err_len;
        logic       exp_err_uf;
    } vec_t;

    vec_t vecs[$];

    ccip_c0_line_credit #(
        .MAX_ACTIVE_LINES(MAX),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_cl_len(req_cl_len),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .clr_peak(clr_peak),
        .active_lines(active_lines),
        .peak_lines(peak_lines),
        .err_len(err_len),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic v, input logic [1:0] len, input logic rsp,
                           input logic clr, input logic rdy, input int act,
                           input int pk, input logic el, input logic eu);
        vec_t t;
        t.valid = v; t.cl_len = len; t.rsp = rsp; t.clr = clr;
        t.exp_ready = rdy; t.exp_active = act; t.exp_peak = pk;
        t.exp_err_len = el; t.exp_err_uf = eu;
        vecs.push_back(t);
    endtask

    // Drive one cycle at the falling edge, check ready combinationally, then
    // check registered state just after the following rising edge.
    task automatic step(input string tag, input logic v, input logic [1:0] len,
                        input logic rsp, input logic clr, input logic rdy,
                        input int act, input int pk, input logic el, input logic eu);
        @(negedge clk);
        req_valid  = v;
        req_cl_len = len;
        rsp_valid  = rsp;
        clr_peak   = clr;
        #1;
        check({tag, ".ready"}, int'(req_ready), int'(rdy));
        @(posedge clk);
        #1;
        check({tag, ".active"}, int'(active_lines), act);
        check({tag, ".peak"}, int'(peak_lines), pk);
        check({tag, ".err_len"}, int'(err_len), int'(el));
        check({tag, ".err_uf"}, int'(err_underflow), int'(eu));
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0; req_cl_len = 2'd0; rsp_valid = 1'b0; clr_peak = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req_valid = 1'b0; req_cl_len = 2'd0; rsp_valid = 1'b0; clr_peak = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_cl_len = 2'd0;
        rsp_valid  = 1'b0;
        clr_peak   = 1'b0;

        //       v  len  rsp clr rdy act pk el eu
        add_vec(1, 2'd3, 0, 0, 1, 4, 4, 0, 0); // fill: first 4-line accept
        add_vec(1, 2'd3, 0, 0, 1, 8, 8, 0, 0); // fill: second, reaches MAX
        add_vec(1, 2'd3, 0, 0, 0, 8, 8, 0, 0); // full: held
        add_vec(1, 2'd0, 0, 0, 0, 8, 8, 0, 0); // 1 line does not fit at 8
        add_vec(0, 2'd0, 1, 0, 0, 7, 8, 0, 0); // rsp only; ready ignores valid
        add_vec(0, 2'd0, 0, 0, 1, 7, 8, 0, 0); // boundary: 7+1 fits
        add_vec(0, 2'd1, 0, 0, 0, 7, 8, 0, 0); // boundary: 7+2 does not
        add_vec(1, 2'd0, 0, 0, 1, 8, 8, 0, 0); // accept 1 line -> 8
        add_vec(0, 2'd0, 1, 0, 0, 7, 8, 0, 0);
        add_vec(0, 2'd0, 1, 0, 1, 6, 8, 0, 0);
        add_vec(0, 2'd0, 1, 0, 1, 5, 8, 0, 0);
        add_vec(1, 2'd1, 1, 0, 1, 6, 8, 0, 0); // 5 + 2 - 1 = 6
        add_vec(0, 2'd0, 1, 1, 1, 5, 5, 0, 0); // clr_peak loads next active
        add_vec(1, 2'd2, 0, 0, 0, 5, 5, 1, 0); // illegal length
        add_vec(0, 2'd2, 0, 0, 0, 5, 5, 1, 0); // illegal len, not offered
        add_vec(1, 2'd3, 1, 0, 0, 4, 5, 1, 0); // 5+4 > 8 refused, rsp retires
        add_vec(1, 2'd3, 1, 0, 1, 7, 7, 1, 0); // 4+4-1 = 7, peak rises
        add_vec(0, 2'd0, 0, 1, 1, 7, 7, 1, 0); // clr_peak leaves flags alone

        // Reset state, including ready evaluated with active_lines = 0.
        #2;
        check("rst.active", int'(active_lines), 0);
        check("rst.peak", int'(peak_lines), 0);
        check("rst.err_len", int'(err_len), 0);
        check("rst.err_uf", int'(err_underflow), 0);
        req_cl_len = 2'd3;
        #1;
        check("rst.ready_len4", int'(req_ready), 1);
        req_cl_len = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].cl_len, vecs[i].rsp,
                 vecs[i].clr, vecs[i].exp_ready, vecs[i].exp_active,
                 vecs[i].exp_peak, vecs[i].exp_err_len, vecs[i].exp_err_uf);
        end

        // err_len clears only on reset.
        do_reset();
        #1;
        check("reset1.err_len", int'(err_len), 0);

        // Accept together with rsp at zero: n-1, no underflow.
        step("uf_accept", 1, 2'd3, 1, 0, 1, 3, 3, 0, 0);
        step("drain3", 0, 2'd0, 1, 0, 1, 2, 3, 0, 0);
        step("drain2", 0, 2'd0, 1, 0, 1, 1, 3, 0, 0);
        step("drain1", 0, 2'd0, 1, 0, 1, 0, 3, 0, 0);
        // Stray response at zero: hold and flag.
        step("uf_stray", 0, 2'd0, 1, 0, 1, 0, 3, 0, 1);
        step("uf_sticky", 1, 2'd0, 0, 1, 1, 1, 1, 0, 1);
        step("uf_sticky2", 0, 2'd0, 0, 0, 1, 1, 1, 0, 1);

        // Reset mid-flight: build active=6, peak=8, then drop reset between edges.
        do_reset();
        step("mf_a", 1, 2'd3, 0, 0, 1, 4, 4, 0, 0);
        step("mf_b", 1, 2'd3, 0, 0, 1, 8, 8, 0, 0);
        step("mf_c", 0, 2'd0, 1, 0, 0, 7, 8, 0, 0);
        step("mf_d", 1, 2'd2, 1, 0, 0, 6, 8, 1, 0);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        check("mf_rst.active", int'(active_lines), 0);
        check("mf_rst.peak", int'(peak_lines), 0);
        check("mf_rst.err_len", int'(err_len), 0);
        check("mf_rst.ready", int'(req_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        step("mf_after", 1, 2'd0, 0, 0, 1, 1, 1, 0, 0);

        idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
